// File: rtl/conv_window_feeder_if.sv
// Stream bundle between the pixel source, the window feeder and the 4x4 MAC stage.
// Both sides are valid/ready: a beat moves on a cycle where valid && ready are both high.
interface conv_window_if #(
  parameter int lenOfInput = 8
);
  logic                          in_valid;
  logic                          in_ready;
  logic signed [lenOfInput-1:0]  in_pixel;
  logic                          out_valid;
  logic                          out_ready;
  logic [16*lenOfInput-1:0]      out_window;
  logic                          out_last;

  modport master (
    output in_valid, in_pixel, out_ready,
    input  in_ready, out_valid, out_window, out_last
  );

  modport slave (
    input  in_valid, in_pixel, out_ready,
    output in_ready, out_valid, out_window, out_last
  );
endinterface

// File: rtl/conv_window_feeder.sv
// Raster pixel stream -> every stride-1 4x4 window, using three line buffers and a
// 4x4 shift window. A single output register holds the window, with pass-through on drain.
module conv_window_feeder #(
  parameter int lenOfInput = 8,
  parameter int IMG_W      = 8,
  parameter int IMG_H      = 8
) (
  input logic          clk,
  input logic          rst,
  conv_window_if.slave bus
);
  localparam int PW = lenOfInput;
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_WIN  = CW'(3);
  localparam logic [RW-1:0] ROW_WIN  = RW'(3);

  typedef logic signed [PW-1:0] pix_t;

  pix_t lb0_q [IMG_W];
  pix_t lb1_q [IMG_W];
  pix_t lb2_q [IMG_W];
  pix_t win_q [4][4];
  pix_t win_d [4][4];
  pix_t col_vec [4];

  logic [CW-1:0]      col_q, col_d;
  logic [RW-1:0]      row_q, row_d;
  logic               out_valid_q, out_valid_d;
  logic               out_last_q, out_last_d;
  logic [16*PW-1:0]   out_window_q, out_window_d;
  logic               accept;
  logic               emit;

  assign bus.in_ready   = !out_valid_q || bus.out_ready;
  assign accept         = bus.in_valid && bus.in_ready;
  assign emit           = accept && (row_q >= ROW_WIN) && (col_q >= COL_WIN);
  assign bus.out_valid  = out_valid_q;
  assign bus.out_last   = out_last_q;
  assign bus.out_window = out_window_q;

  // Column entering the window's right edge: r=0 is the oldest row.
  always_comb begin
    col_vec[0] = lb0_q[col_q];
    col_vec[1] = lb1_q[col_q];
    col_vec[2] = lb2_q[col_q];
    col_vec[3] = bus.in_pixel;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        win_d[r][c] = win_q[r][c];
      end
    end
    if (accept) begin
      for (int r = 0; r < 4; r++) begin
        for (int c = 0; c < 3; c++) begin
          win_d[r][c] = win_q[r][c+1];
        end
        win_d[r][3] = col_vec[r];
      end
    end
  end

  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    out_valid_d  = out_valid_q;
    out_last_d   = out_last_q;
    out_window_d = out_window_q;
    if (accept) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
    // A new window replaces the held one; otherwise a drain empties the register.
    if (emit) begin
      out_valid_d = 1'b1;
      out_last_d  = (row_q == ROW_LAST) && (col_q == COL_LAST);
      for (int r = 0; r < 4; r++) begin
        for (int c = 0; c < 4; c++) begin
          out_window_d[(r*4+c)*PW +: PW] = win_d[r][c];
        end
      end
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q        <= '0;
      row_q        <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      out_window_q <= '0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
      out_window_q <= out_window_d;
    end
  end

  // Line buffers and the shift window carry no reset: nothing stale is ever emitted.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb0_q[col_q] <= col_vec[1];
      lb1_q[col_q] <= col_vec[2];
      lb2_q[col_q] <= col_vec[3];
    end
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        win_q[r][c] <= win_d[r][c];
      end
    end
  end
endmodule

// File: tb/tb_conv_window_feeder.sv
// Bench for conv_window_feeder: three instances (6x5, 4x4, 8x8) checked every cycle
// against a frame-array model that cuts each 4x4 window straight out of the image.
module tb_conv_window_feeder;
  localparam int PW = 8;
  localparam int WW = 16 * PW;
  localparam int IW [3] = '{6, 4, 8};
  localparam int IH [3] = '{5, 4, 8};
  localparam logic [WW-1:0] FIRST_W  = 128'h15141312_0f0e0d0c_09080706_03020100;
  localparam logic [WW-1:0] LAST_W   = 128'h1d1c1b1a_17161514_11100f0e_0b0a0908;
  localparam logic [WW-1:0] SECOND_W = 128'h79787776_73727170_6d6c6b6a_67666564;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst0, rst12;

  conv_window_if #(.lenOfInput(PW)) bus0 ();
  conv_window_if #(.lenOfInput(PW)) bus1 ();
  conv_window_if #(.lenOfInput(PW)) bus2 ();

  conv_window_feeder #(.lenOfInput(PW), .IMG_W(6), .IMG_H(5)) dut0 (.clk(clk), .rst(rst0),  .bus(bus0.slave));
  conv_window_feeder #(.lenOfInput(PW), .IMG_W(4), .IMG_H(4)) dut1 (.clk(clk), .rst(rst12), .bus(bus1.slave));
  conv_window_feeder #(.lenOfInput(PW), .IMG_W(8), .IMG_H(8)) dut2 (.clk(clk), .rst(rst12), .bus(bus2.slave));

  // scoreboard state
  int n_checks = 0;
  int n_errs   = 0;
  logic [PW-1:0] pix [3][8][8];
  logic [WW:0]   exp_q [3][$];
  bit  seen_rst [3];
  bit  was_rst  [3];
  int  mr [3];
  int  mc [3];
  int  n_out [3];
  int  n_emit [3];
  int  timeouts = 0;
  bit  final_req = 1'b0;
  bit  final_done = 1'b0;
  bit  bp_arm = 1'b0;
  int  bp_cnt = 0;

  task automatic chk1(input int i, input string nm, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL inst%0d %s: got %b expected %b", i, nm, act, exp);
    end
  endtask

  task automatic chkw(input int i, input string nm, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL inst%0d %s: got %h expected %h", i, nm, act, exp);
    end
  endtask

  task automatic chkn(input int i, input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errs++;
      $display("FAIL inst%0d %s: got %0d expected %0d", i, nm, act, exp);
    end
  endtask

  // Hand-computed windows that pin the model itself.
  task automatic pin_literals(input int i, input int idx, input logic [WW-1:0] w, input logic l);
    if (i == 0) begin
      chk1(i, "last_flag_position", l, (idx % 6) == 5);
      if (idx == 0 || idx == 18) chkw(i, "first_window_literal", w, FIRST_W);
      if (idx == 5 || idx == 23) chkw(i, "last_window_literal", w, LAST_W);
      if (idx == 6) chkw(i, "frame2_first_literal", w, SECOND_W);
    end else if (i == 1) begin
      chkw(i, "sign_window_literal", w, {16{8'h80}});
      chk1(i, "sign_last_literal", l, 1'b1);
    end
  endtask

  task automatic step(input int i, input logic rs, input logic iv, input logic ir,
                      input logic [PW-1:0] px, input logic ov, input logic orr,
                      input logic [WW-1:0] ow, input logic ol);
    logic [WW-1:0] win;
    logic [WW:0]   item;
    bit pend, acc, is_last;
    pend = exp_q[i].size() != 0;
    if (seen_rst[i]) begin
      chk1(i, "out_valid", ov, pend);
      chk1(i, "in_ready", ir, !pend || orr);
      if (was_rst[i]) begin
        chkw(i, "reset_window", ow, '0);
        chk1(i, "reset_last", ol, 1'b0);
      end else if (pend) begin
        item = exp_q[i][0];
        chkw(i, "window", ow, item[WW-1:0]);
        chk1(i, "last", ol, item[WW]);
      end
    end
    if (rs) begin
      seen_rst[i] = 1'b1;
      was_rst[i]  = 1'b1;
      exp_q[i].delete();
      mr[i] = 0;
      mc[i] = 0;
    end else if (seen_rst[i]) begin
      was_rst[i] = 1'b0;
      acc = iv && (!pend || orr);
      if (pend && orr) begin
        item = exp_q[i].pop_front();
        pin_literals(i, n_out[i], item[WW-1:0], item[WW]);
        n_out[i]++;
      end
      if (acc) begin
        pix[i][mr[i]][mc[i]] = px;
        if (mr[i] >= 3 && mc[i] >= 3) begin
          win = '0;
          for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
              win[(r*4+c)*PW +: PW] = pix[i][mr[i]-3+r][mc[i]-3+c];
          is_last = (mr[i] == IH[i]-1) && (mc[i] == IW[i]-1);
          exp_q[i].push_back({is_last, win});
          n_emit[i]++;
        end
        if (mc[i] == IW[i]-1) begin
          mc[i] = 0;
          mr[i] = (mr[i] == IH[i]-1) ? 0 : mr[i] + 1;
        end else begin
          mc[i]++;
        end
      end
    end
  endtask

  // single compare process
  always @(negedge clk) begin
    step(0, rst0,  bus0.in_valid, bus0.in_ready, bus0.in_pixel, bus0.out_valid, bus0.out_ready, bus0.out_window, bus0.out_last);
    step(1, rst12, bus1.in_valid, bus1.in_ready, bus1.in_pixel, bus1.out_valid, bus1.out_ready, bus1.out_window, bus1.out_last);
    step(2, rst12, bus2.in_valid, bus2.in_ready, bus2.in_pixel, bus2.out_valid, bus2.out_ready, bus2.out_window, bus2.out_last);
    if (final_req && !final_done) begin
      final_done = 1'b1;
      chkn(0, "windows_total", n_out[0], 24);
      chkn(1, "windows_total", n_out[1], 1);
      chkn(2, "windows_total", n_out[2], 50);
      chkn(2, "model_window_formula", n_emit[2], (IW[2]-3)*(IH[2]-3)*2);
      for (int k = 0; k < 3; k++) begin
        chkn(k, "drained_vs_emitted", n_out[k], n_emit[k]);
        chkn(k, "pending_at_end", exp_q[k].size(), 0);
      end
      chkn(0, "handshake_timeouts", timeouts, 0);
    end
  end

  // driver tasks
  task automatic set_in(input int i, input logic v, input logic [PW-1:0] p);
    case (i)
      0: begin bus0.in_valid = v; bus0.in_pixel = p; end
      1: begin bus1.in_valid = v; bus1.in_pixel = p; end
      default: begin bus2.in_valid = v; bus2.in_pixel = p; end
    endcase
  endtask

  task automatic set_oready(input int i, input logic r);
    case (i)
      0: bus0.out_ready = r;
      1: bus1.out_ready = r;
      default: bus2.out_ready = r;
    endcase
  endtask

  function automatic logic get_ready(input int i);
    case (i)
      0: return bus0.in_ready;
      1: return bus1.in_ready;
      default: return bus2.in_ready;
    endcase
  endfunction

  task automatic tick(input int i, input bit rnd);
    if (rnd) begin
      set_oready(i, 1'($urandom_range(0, 1)));
    end else if (i == 0 && bp_arm) begin
      if (bus0.out_valid) bp_cnt++;
      set_oready(0, bp_cnt >= 5);
      if (bp_cnt >= 5) bp_arm = 1'b0;
    end
  endtask

  task automatic idle(input int i, input bit rnd);
    @(posedge clk);
    #1;
    tick(i, rnd);
  endtask

  task automatic send(input int i, input logic [PW-1:0] p, input bit rnd);
    int budget;
    bit ok;
    budget = 0;
    ok = 1'b0;
    while (rnd && $urandom_range(0, 1) == 0) idle(i, rnd);
    set_in(i, 1'b1, p);
    while (!ok && budget < 300) begin
      @(negedge clk);
      ok = get_ready(i);
      @(posedge clk);
      #1;
      tick(i, rnd);
      budget++;
    end
    if (!ok) timeouts++;
    set_in(i, 1'b0, '0);
  endtask

  task automatic frame(input int i, input int base, input int mode, input bit rnd);
    for (int r = 0; r < IH[i]; r++) begin
      for (int c = 0; c < IW[i]; c++) begin
        logic [PW-1:0] p;
        case (mode)
          0: p = PW'(base + r*IW[i] + c);
          1: p = PW'(base);
          default: p = PW'($urandom_range(0, 255));
        endcase
        send(i, p, rnd);
      end
    end
  endtask

  initial begin
    rst0 = 1'b1;
    rst12 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      set_in(k, 1'b0, '0);
      set_oready(k, 1'b1);
    end
    repeat (3) @(posedge clk);
    #1;
    rst0 = 1'b0;
    rst12 = 1'b0;

    // basic raster and a back-to-back second frame
    frame(0, 0, 0, 1'b0);
    frame(0, 100, 0, 1'b0);
    repeat (4) idle(0, 1'b0);

    // backpressure: out_ready low until the first window has stalled 5 cycles
    bp_cnt = 0;
    bp_arm = 1'b1;
    set_oready(0, 1'b0);
    frame(0, 50, 0, 1'b0);
    if (bp_arm) begin
      timeouts++;
      bp_arm = 1'b0;
      set_oready(0, 1'b1);
    end
    repeat (4) idle(0, 1'b0);

    // reset mid-frame, then a full basic frame
    for (int k = 0; k < 15; k++) send(0, PW'(k), 1'b0);
    rst0 = 1'b1;
    repeat (2) idle(0, 1'b0);
    rst0 = 1'b0;
    frame(0, 0, 0, 1'b0);
    repeat (4) idle(0, 1'b0);

    // sign passthrough on 4x4
    frame(1, 8'h80, 1, 1'b0);
    repeat (4) idle(1, 1'b0);

    // random valid/ready and pixels on 8x8, two frames
    frame(2, 0, 2, 1'b1);
    frame(2, 0, 2, 1'b1);
    set_oready(2, 1'b1);
    repeat (6) idle(2, 1'b0);

    final_req = 1'b1;
    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end
endmodule
